// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file port scheduler.
// The scheduler state encoding and the MIPS $0 index live here.
package regfile_sched_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_A,
    RD_B,
    RESP
  } state_t;

endpackage

// File: rtl/regfile_port_scheduler.sv
// Serialises one write-back write and two decode reads onto a single-port
// register file, enforcing write-before-read ordering and $0 semantics.
module regfile_port_scheduler
  import regfile_sched_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ack,
  input  logic              id_req,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic              id_ack,
  output logic [DATA_W-1:0] id_rdata_a,
  output logic [DATA_W-1:0] id_rdata_b,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_write_mode,
  output logic              rf_read_mode,
  output logic              rf_chip_select,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wb_addr_q, rs_q, rt_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              cap_wb, cap_id;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx       = state;
    cap_wb         = 1'b0;
    cap_id         = 1'b0;
    wb_ack         = 1'b0;
    id_ack         = 1'b0;
    rf_addr        = '0;
    rf_wdata       = '0;
    rf_write_mode  = 1'b0;
    rf_read_mode   = 1'b0;
    rf_chip_select = 1'b0;

    unique case (state)
      IDLE: begin
        if (wb_req) begin
          state_nx = WR;
          cap_wb   = 1'b1;
        end else if (id_req) begin
          state_nx = RD_A;
          cap_id   = 1'b1;
        end
      end
      WR: begin
        rf_addr        = wb_addr_q;
        rf_wdata       = wb_data_q;
        rf_write_mode  = 1'b1;
        rf_chip_select = (wb_addr_q != ZERO_IDX);
        wb_ack         = 1'b1;
        // A pending read goes next, so the writer cannot starve the reader.
        if (id_req) begin
          state_nx = RD_A;
          cap_id   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RD_A: begin
        rf_addr        = rs_q;
        rf_read_mode   = 1'b1;
        rf_chip_select = (rs_q != ZERO_IDX);
        state_nx       = RD_B;
      end
      RD_B: begin
        rf_addr        = rt_q;
        rf_read_mode   = 1'b1;
        rf_chip_select = (rt_q != ZERO_IDX);
        state_nx       = RESP;
      end
      RESP: begin
        id_ack = 1'b1;
        if (wb_req) begin
          state_nx = WR;
          cap_wb   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      id_rdata_a <= '0;
      id_rdata_b <= '0;
    end else begin
      state <= state_nx;
      if (cap_wb) begin
        wb_addr_q <= wb_addr;
        wb_data_q <= wb_data;
      end
      if (cap_id) begin
        rs_q <= id_rs;
        rt_q <= id_rt;
      end
      // rf_rdata is only trusted in read states; $0 never looks at it.
      if (state == RD_A) id_rdata_a <= (rs_q == ZERO_IDX) ? '0 : rf_rdata;
      if (state == RD_B) id_rdata_b <= (rt_q == ZERO_IDX) ? '0 : rf_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Randomised scoreboard bench for regfile_port_scheduler with a behavioural
// register file beside it and an array-based reference model.
module tb_regfile_port_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_req, id_req;
  logic [AW-1:0] wb_addr, id_rs, id_rt;
  logic [DW-1:0] wb_data;
  logic          wb_ack, id_ack, busy;
  logic [DW-1:0] id_rdata_a, id_rdata_b;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic          rf_write_mode, rf_read_mode, rf_chip_select;
  wire  [DW-1:0] rf_rdata;

  always #5 clk = ~clk;

  regfile_port_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .id_req(id_req), .id_rs(id_rs), .id_rt(id_rt), .id_ack(id_ack),
    .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b), .busy(busy),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_write_mode(rf_write_mode),
    .rf_read_mode(rf_read_mode), .rf_chip_select(rf_chip_select),
    .rf_rdata(rf_rdata)
  );

  // Plain storage array standing in for the real register file; floats Z
  // whenever it is not being read.
  logic [DW-1:0] rf_mem [32];
  assign rf_rdata = (rf_chip_select && rf_read_mode) ? rf_mem[rf_addr] : 'z;
  always @(posedge clk)
    if (rf_chip_select && rf_write_mode) rf_mem[rf_addr] <= rf_wdata;

  // Reference model: architectural register contents with $0 hard-wired.
  logic [DW-1:0] ref_mem [32];

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_rd[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr.push_back('{addr: a, data: d});
    if (a != 0) ref_mem[a] = d;
  endfunction

  function automatic void model_read(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    exp_rd.push_back('{a: ref_mem[rs], b: ref_mem[rt]});
  endfunction

  // Monitor: pops the scoreboard whenever the DUT acknowledges.
  wr_t mon_w;
  rd_t mon_r;
  always @(negedge clk) begin
    if (!rst) begin
      check("rdata_known", {31'b0, $isunknown({id_rdata_a, id_rdata_b})}, 32'd0);
      check("write_only_on_ack", {31'b0, rf_write_mode}, {31'b0, wb_ack});
      if (wb_ack) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb_ack: got ack expected none at %0t", $time);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_rf_addr", {27'b0, rf_addr}, {27'b0, mon_w.addr});
          check("wr_rf_wdata", rf_wdata, mon_w.data);
          check("wr_read_mode", {31'b0, rf_read_mode}, 32'd0);
          check("wr_chip_select", {31'b0, rf_chip_select}, {31'b0, mon_w.addr != 0});
        end
      end
      if (id_ack) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_id_ack: got ack expected none at %0t", $time);
        end else begin
          mon_r = exp_rd.pop_front();
          check("rdata_a", id_rdata_a, mon_r.a);
          check("rdata_b", id_rdata_b, mon_r.b);
          check("resp_no_rf_access", {31'b0, rf_chip_select}, 32'd0);
        end
      end
    end
  end

  // One isolated transaction round from IDLE: write, read, or both at once.
  task automatic round(input bit do_wr, input bit do_rd,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    int wc, rc;
    wc = -1;
    rc = -1;
    check("idle_before_round", {31'b0, busy}, 32'd0);
    if (do_wr) model_write(wa, wd);
    if (do_rd) model_read(rs, rt);
    wb_req = do_wr; wb_addr = wa; wb_data = wd;
    id_req = do_rd; id_rs = rs;   id_rt = rt;
    for (int c = 1; c <= 12 && (wb_req || id_req); c++) begin
      @(negedge clk);
      check("busy_in_flight", {31'b0, busy}, 32'd1);
      if (wb_req && wb_ack) begin wc = c; wb_req = 1'b0; end
      if (id_req && id_ack) begin rc = c; id_req = 1'b0; end
    end
    wb_req = 1'b0;
    id_req = 1'b0;
    if (do_wr) check("wb_latency", wc, 1);
    if (do_rd) check("id_latency", rc, do_wr ? 4 : 3);
    @(negedge clk);
  endtask

  // Back-to-back requesters for the alternation test.
  localparam int NALT = 20;
  logic [AW-1:0] alt_wa [NALT];
  logic [DW-1:0] alt_wd [NALT];
  logic [AW-1:0] alt_rs [NALT];
  logic [AW-1:0] alt_rt [NALT];

  task automatic alt_writer();
    for (int k = 0; k < NALT; k++) begin
      int lat;
      lat = -1;
      wb_addr = alt_wa[k]; wb_data = alt_wd[k]; wb_req = 1'b1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        @(negedge clk);
        if (wb_ack) lat = c;
      end
      wb_req = 1'b0;
      check("alt_wb_latency", lat, (k == 0) ? 1 : 3);
      @(negedge clk);
    end
  endtask

  task automatic alt_reader();
    for (int k = 0; k < NALT; k++) begin
      int lat;
      lat = -1;
      id_rs = alt_rs[k]; id_rt = alt_rt[k]; id_req = 1'b1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        @(negedge clk);
        if (id_ack) lat = c;
      end
      id_req = 1'b0;
      check("alt_id_latency", lat, (k == 0) ? 4 : 3);
      @(negedge clk);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_acks"}, {30'b0, wb_ack, id_ack}, 32'd0);
    check({tag, "_rdata_a"}, id_rdata_a, 32'd0);
    check({tag, "_rdata_b"}, id_rdata_b, 32'd0);
    check({tag, "_rf_addr"}, {27'b0, rf_addr}, 32'd0);
    check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    check({tag, "_rf_ctrl"}, {29'b0, rf_write_mode, rf_read_mode, rf_chip_select}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      rf_mem[i]  = v;
      ref_mem[i] = (i == 0) ? '0 : v;
    end
    rf_mem[0] = 32'hBAD0_BAD0;

    rst = 1'b1;
    wb_req = 1'b0; wb_addr = '0; wb_data = '0;
    id_req = 1'b0; id_rs = '0;   id_rt = '0;
    repeat (2) @(negedge clk);
    check_outputs_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    round(1, 0, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    round(0, 1, 5'd0, 32'h0, 5'd5, 5'd0);
    round(1, 1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    round(1, 0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    round(0, 1, 5'd0, 32'h0, 5'd0, 5'd0);

    // Randomised rounds.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    kind;
      logic [AW-1:0] wa, rs, rt;
      kind = 2'($urandom_range(1, 3));
      wa   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rt   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      round(kind[0], kind[1], wa, $urandom, rs, rt);
    end

    // Reset in the middle of RD_B drops the read with no ack.
    id_rs = 5'd5; id_rt = 5'd7; id_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_outputs_reset("mid_reset");
    @(negedge clk);
    check("mid_reset_no_ack", {31'b0, id_ack}, 32'd0);
    id_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    round(0, 1, 5'd0, 32'h0, 5'd5, 5'd7);

    // Alternation under continuous pressure from both requesters.
    for (int k = 0; k < NALT; k++) begin
      alt_wa[k] = 5'($urandom_range(0, 31));
      alt_wd[k] = $urandom;
      alt_rs[k] = alt_wa[k];
      alt_rt[k] = 5'($urandom_range(0, 31));
      model_write(alt_wa[k], alt_wd[k]);
      model_read(alt_rs[k], alt_rt[k]);
    end
    fork
      alt_writer();
      alt_reader();
    join
    repeat (3) @(negedge clk);
    check("alt_idle_after", {31'b0, busy}, 32'd0);

    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
